// File: rtl/sample_framer.sv
`default_nettype none
// ============================================================================
// Module   : sample_framer
// Purpose  : Assembles a valid/ready stream of signed 12-bit samples into
//            8-sample windows with a hop of 4 or 8 samples and presents each
//            window, with a frame index, on eight parallel outputs.
// Revision : 1.0 - initial release
// ============================================================================
module sample_framer #(
  parameter int HOP   = 8,
  parameter int IDX_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [11:0]      s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    flush,
  output logic signed [11:0]      frame0,
  output logic signed [11:0]      frame1,
  output logic signed [11:0]      frame2,
  output logic signed [11:0]      frame3,
  output logic signed [11:0]      frame4,
  output logic signed [11:0]      frame5,
  output logic signed [11:0]      frame6,
  output logic signed [11:0]      frame7,
  output logic                    f_valid,
  input  logic                    f_ready,
  output logic [IDX_W-1:0]        frame_idx
);

  localparam logic [3:0] c_FULL = 4'd8;
  localparam logic [3:0] c_HOP  = 4'(HOP);

  // Only 50 % overlap or no overlap is meaningful for the 8-point path.
  generate
    if (HOP != 4 && HOP != 8) begin : g_bad_hop
      $error("sample_framer: HOP must be 4 or 8");
    end
  endgenerate

  logic [11:0]      hist_q [8];
  logic [11:0]      hist_d [8];
  logic [11:0]      out_q  [8];
  logic [11:0]      out_d  [8];
  logic [3:0]       fill_q, fill_d;
  logic [3:0]       ncnt_q, ncnt_d;
  logic             f_valid_q, f_valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic       accept;
  logic       consume;
  logic       next_completes;
  logic       completes;
  logic [3:0] fill_inc;
  logic [3:0] ncnt_inc;

  // Handshake decode; whether the next sample would close a window depends
  // only on registered counters, so only f_ready and flush reach s_ready
  // combinationally. The first window after a restart needs ncnt to reach 8,
  // which is implied by fill reaching 8 since both restart together.
  always_comb begin
    fill_inc       = (fill_q == c_FULL) ? c_FULL : fill_q + 4'd1;
    ncnt_inc       = ncnt_q + 4'd1;
    next_completes = (fill_inc == c_FULL) && (ncnt_inc >= c_HOP);
    s_ready        = flush || !(next_completes && f_valid_q && !f_ready);
    accept         = s_valid && s_ready;
    consume        = f_valid_q && f_ready;
    completes      = accept && !flush && next_completes;
  end

  // Next-state: history shift, counters, window capture and frame index.
  always_comb begin
    hist_d    = hist_q;
    out_d     = out_q;
    fill_d    = fill_q;
    ncnt_d    = ncnt_q;
    f_valid_d = f_valid_q;
    idx_d     = idx_q;

    if (accept) begin
      for (int k = 0; k < 7; k++) begin
        hist_d[k] = hist_q[k + 1];
      end
      hist_d[7] = s_data;
    end

    if (flush) begin
      // A sample taken alongside flush is the first of the new window.
      fill_d = accept ? 4'd1 : 4'd0;
      ncnt_d = accept ? 4'd1 : 4'd0;
    end else if (accept) begin
      fill_d = fill_inc;
      ncnt_d = completes ? 4'd0 : ncnt_inc;
    end

    if (consume) begin
      f_valid_d = 1'b0;
      idx_d     = idx_q + IDX_W'(1);
    end

    // A completion overrides a same-cycle consume: the new window follows.
    if (completes) begin
      out_d     = hist_d;
      f_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        hist_q[k] <= 12'd0;
        out_q[k]  <= 12'd0;
      end
      fill_q    <= 4'd0;
      ncnt_q    <= 4'd0;
      f_valid_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      hist_q    <= hist_d;
      out_q     <= out_d;
      fill_q    <= fill_d;
      ncnt_q    <= ncnt_d;
      f_valid_q <= f_valid_d;
      idx_q     <= idx_d;
    end
  end

  assign frame0    = out_q[0];
  assign frame1    = out_q[1];
  assign frame2    = out_q[2];
  assign frame3    = out_q[3];
  assign frame4    = out_q[4];
  assign frame5    = out_q[5];
  assign frame6    = out_q[6];
  assign frame7    = out_q[7];
  assign f_valid   = f_valid_q;
  assign frame_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_framer
// Purpose  : Directed scoreboard bench for sample_framer with HOP=8 (dut 0)
//            and HOP=4 (dut 1) instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_framer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] s_data;
  logic        s_valid [2];
  logic        flush   [2];
  logic        f_ready [2];
  logic        s_ready [2];
  logic        f_valid [2];
  logic [11:0] fr      [2][8];
  logic [7:0]  fidx    [2];

  sample_framer #(.HOP(8), .IDX_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .flush(flush[0]),
    .frame0(fr[0][0]), .frame1(fr[0][1]), .frame2(fr[0][2]), .frame3(fr[0][3]),
    .frame4(fr[0][4]), .frame5(fr[0][5]), .frame6(fr[0][6]), .frame7(fr[0][7]),
    .f_valid(f_valid[0]), .f_ready(f_ready[0]), .frame_idx(fidx[0])
  );

  sample_framer #(.HOP(4), .IDX_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .flush(flush[1]),
    .frame0(fr[1][0]), .frame1(fr[1][1]), .frame2(fr[1][2]), .frame3(fr[1][3]),
    .frame4(fr[1][4]), .frame5(fr[1][5]), .frame6(fr[1][6]), .frame7(fr[1][7]),
    .f_valid(f_valid[1]), .f_ready(f_ready[1]), .frame_idx(fidx[1])
  );

  typedef struct packed {
    logic [7:0]  idx;
    logic [95:0] w;
  } exp_t;

  exp_t q8 [$];
  exp_t q4 [$];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_fv   [2];
  logic prev_cons [2];
  logic acc       [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_raw(input int sel, input logic [95:0] w, input int idx);
    exp_t e;
    e.w   = w;
    e.idx = 8'(idx);
    if (sel == 0) q8.push_back(e);
    else          q4.push_back(e);
  endtask

  // Expected window of consecutive sample values first..first+7.
  task automatic push(input int sel, input int first, input int idx);
    logic [95:0] w;
    for (int k = 0; k < 8; k++) w[12*k +: 12] = 12'(first + k);
    push_raw(sel, w, idx);
  endtask

  // A new window is on the outputs when f_valid rises or stays high after a consume.
  task automatic monitor(input int s);
    exp_t e;
    int   qs;
    if (f_valid[s] && (!prev_fv[s] || prev_cons[s])) begin
      qs = (s == 0) ? q8.size() : q4.size();
      if (qs == 0) begin
        chk($sformatf("dut%0d unexpected window", s), 32'(f_valid[s]), 32'd0);
      end else begin
        e = (s == 0) ? q8.pop_front() : q4.pop_front();
        for (int k = 0; k < 8; k++)
          chk($sformatf("dut%0d win%0d frame%0d", s, e.idx, k), 32'(fr[s][k]), 32'(e.w[12*k +: 12]));
        chk($sformatf("dut%0d frame_idx", s), 32'(fidx[s]), 32'(e.idx));
      end
    end
    prev_fv[s] = f_valid[s];
  endtask

  // One clock: record handshakes just before the edge, check after it.
  task automatic tick();
    #1;
    for (int s = 0; s < 2; s++) begin
      prev_cons[s] = f_valid[s] && f_ready[s];
      acc[s]       = s_valid[s] && s_ready[s];
    end
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) monitor(s);
  endtask

  task automatic send(input int sel, input int val, output int waits);
    s_data       = 12'(val);
    s_valid[sel] = 1'b1;
    waits        = 0;
    tick();
    while (!acc[sel] && waits < 50) begin
      waits++;
      tick();
    end
    if (!acc[sel]) chk($sformatf("dut%0d send timeout", sel), 32'(acc[sel]), 32'd1);
  endtask

  task automatic idle(input int n);
    s_valid[0] = 1'b0;
    s_valid[1] = 1'b0;
    repeat (n) tick();
  endtask

  // Asserts reset, checks outputs before any clock edge, then releases.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("dut%0d rst s_ready", s), 32'(s_ready[s]), 32'd1);
      chk($sformatf("dut%0d rst f_valid", s), 32'(f_valid[s]), 32'd0);
      chk($sformatf("dut%0d rst frame_idx", s), 32'(fidx[s]), 32'd0);
      for (int k = 0; k < 8; k++)
        chk($sformatf("dut%0d rst frame%0d", s, k), 32'(fr[s][k]), 32'd0);
      prev_fv[s]   = 1'b0;
      prev_cons[s] = 1'b0;
      s_valid[s]   = 1'b0;
      flush[s]     = 1'b0;
    end
    chk("dut0 windows pending", 32'(q8.size()), 32'd0);
    chk("dut1 windows pending", 32'(q4.size()), 32'd0);
    q8.delete();
    q4.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int          w;
    logic [11:0] ext [8];
    logic [95:0] ew;

    s_data = 12'd0;
    for (int s = 0; s < 2; s++) begin
      s_valid[s] = 1'b0; flush[s] = 1'b0; f_ready[s] = 1'b1;
      prev_fv[s] = 1'b0; prev_cons[s] = 1'b0; acc[s] = 1'b0;
    end
    #2;
    do_reset();

    // HOP=8, free-flowing: windows {1..8} and {9..16}
    push(0, 1, 0);
    push(0, 9, 1);
    for (int v = 1; v <= 16; v++) begin
      send(0, v, w);
      chk($sformatf("hop8 stall s%0d", v), 32'(w), 32'd0);
      chk($sformatf("hop8 f_valid after s%0d", v), 32'(f_valid[0]), 32'(v == 8 || v == 16));
    end
    idle(2);
    chk("hop8 windows missing", 32'(q8.size()), 32'd0);

    // HOP=4, free-flowing: windows {1..8}, {5..12}, {9..16}
    push(1, 1, 0);
    push(1, 5, 1);
    push(1, 9, 2);
    for (int v = 1; v <= 16; v++) begin
      send(1, v, w);
      chk($sformatf("hop4 stall s%0d", v), 32'(w), 32'd0);
      chk($sformatf("hop4 f_valid after s%0d", v), 32'(f_valid[1]), 32'(v == 8 || v == 12 || v == 16));
    end
    idle(2);
    chk("hop4 windows missing", 32'(q4.size()), 32'd0);

    // HOP=8 with downstream stalled: sample 16 must wait for f_ready
    do_reset();
    f_ready[0] = 1'b0;
    push(0, 1, 0);
    for (int v = 1; v <= 15; v++) begin
      send(0, v, w);
      chk($sformatf("bp stall s%0d", v), 32'(w), 32'd0);
    end
    chk("bp f_valid held", 32'(f_valid[0]), 32'd1);
    s_data     = 12'd16;
    s_valid[0] = 1'b1;
    repeat (3) begin
      tick();
      chk("bp s16 taken early", 32'(acc[0]), 32'd0);
      chk("bp s_ready", 32'(s_ready[0]), 32'd0);
      chk("bp frame0 stable", 32'(fr[0][0]), 32'd1);
      chk("bp frame7 stable", 32'(fr[0][7]), 32'd8);
    end
    push(0, 9, 1);
    f_ready[0] = 1'b1;
    #1;
    chk("bp s_ready on f_ready", 32'(s_ready[0]), 32'd1);
    tick();
    chk("bp s16 accepted", 32'(acc[0]), 32'd1);
    idle(1);
    chk("bp f_valid after consume", 32'(f_valid[0]), 32'd0);
    chk("bp windows missing", 32'(q8.size()), 32'd0);

    // Flush with a concurrent sample restarts the window at that sample
    do_reset();
    push(0, 20, 0);
    for (int v = 1; v <= 5; v++) send(0, v, w);
    flush[0] = 1'b1;
    send(0, 20, w);
    chk("flush s_ready", 32'(w), 32'd0);
    flush[0] = 1'b0;
    for (int v = 21; v <= 27; v++) begin
      send(0, v, w);
      chk($sformatf("flush f_valid after s%0d", v), 32'(f_valid[0]), 32'(v == 27));
    end
    idle(2);
    chk("flush windows missing", 32'(q8.size()), 32'd0);

    // Reset while a window is pending, then a fresh window from 30
    do_reset();
    f_ready[0] = 1'b0;
    push(0, 1, 0);
    for (int v = 1; v <= 8; v++) send(0, v, w);
    idle(2);
    chk("pre-reset f_valid", 32'(f_valid[0]), 32'd1);
    chk("pre-reset frame3", 32'(fr[0][3]), 32'd4);
    do_reset();
    f_ready[0] = 1'b1;
    push(0, 30, 0);
    for (int v = 30; v <= 37; v++) send(0, v, w);
    idle(2);
    chk("post-reset windows missing", 32'(q8.size()), 32'd0);

    // Extreme codes pass through bit-exact; frame index now 1
    ext[0] = 12'h800; ext[1] = 12'h7FF; ext[2] = 12'hFFF; ext[3] = 12'h000;
    ext[4] = 12'h001; ext[5] = 12'h801; ext[6] = 12'h7FE; ext[7] = 12'h001;
    for (int k = 0; k < 8; k++) ew[12*k +: 12] = ext[k];
    push_raw(0, ew, 1);
    for (int k = 0; k < 8; k++) send(0, int'(ext[k]), w);
    idle(2);
    chk("extreme windows missing", 32'(q8.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
